// File: rtl/div5_pkg.sv
// Shared mod-15 arithmetic and state encoding for the nibble transmitter and
// the matching divisibility detector.
package div5_pkg;

    localparam int NIBBLE_W = 4;
    localparam int MOD      = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // End-around-carry add; both 0 and 15 stand for residue 0.
    function automatic logic [NIBBLE_W-1:0] add1c(input logic [NIBBLE_W-1:0] a,
                                                  input logic [NIBBLE_W-1:0] b);
        logic [NIBBLE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[NIBBLE_W] ? (s[NIBBLE_W-1:0] + 4'd1) : s[NIBBLE_W-1:0];
    endfunction

    function automatic logic [NIBBLE_W-1:0] check_nibble(input logic [NIBBLE_W-1:0] acc);
        return (acc == 4'h0) ? 4'h0 : ~acc;
    endfunction

endpackage

// File: rtl/mod15_acc.sv
// 4-bit end-around-carry accumulator with synchronous clear and enable.
module mod15_acc
    import div5_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [3:0] i_nibble,
    output logic [3:0] o_acc
);

    logic [3:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= 4'h0;
        end else if (i_en) begin
            r_acc <= add1c(r_acc, i_nibble);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/nibble_tx_mod15.sv
// Streams a word LS nibble first, then a check nibble that makes the
// mod-15 sum of the frame zero.
module nibble_tx_mod15
    import div5_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_nibble,
    output logic                 out_last,
    output logic [1:0]           dbg_state
);

    localparam int N  = BIT_WIDTH / NIBBLE_W;
    localparam int CW = $clog2(N);

    state_t               r_state;
    state_t               w_next_state;
    logic [BIT_WIDTH-1:0] r_shift;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           w_acc;
    logic                 w_in_hs;
    logic                 w_data_hs;
    logic                 w_last_beat;

    assign w_in_hs     = in_valid && (r_state == IDLE);
    assign w_data_hs   = (r_state == SEND) && out_ready;
    assign w_last_beat = (r_cnt == CW'(N - 1));
    assign dbg_state   = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_in_hs) begin
                r_shift <= in_data;
                r_cnt   <= '0;
            end else if (w_data_hs) begin
                r_shift <= r_shift >> NIBBLE_W;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_nibble   = 4'h0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = SEND;
            end
            SEND: begin
                out_valid  = 1'b1;
                out_nibble = r_shift[3:0];
                if (out_ready && w_last_beat) w_next_state = CHECK;
            end
            CHECK: begin
                // acc is frozen here, so the check nibble holds under backpressure.
                out_valid  = 1'b1;
                out_last   = 1'b1;
                out_nibble = check_nibble(w_acc);
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    mod15_acc u_acc (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_in_hs),
        .i_en     (w_data_hs),
        .i_nibble (r_shift[3:0]),
        .o_acc    (w_acc)
    );

endmodule

// File: tb/tb_nibble_tx_mod15.sv
// Bench for nibble_tx_mod15: directed and random frames checked against an
// arithmetic model of the frame (data word plus mod-15 check nibble).
module tb_nibble_tx_mod15;

    localparam int W = 32;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [3:0]   out_nibble;
    logic         out_last;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [W+3:0] exp_q[$];
    logic [W+3:0] got_val;
    logic [W+3:0] exp_val;
    int           got_beats;
    logic         got_last_ok;
    logic         got_timeout;

    always #5 clk = ~clk;

    nibble_tx_mod15 #(.BIT_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nibble (out_nibble),
        .out_last   (out_last),
        .dbg_state  (dbg_state)
    );

    // Frame = word with the check nibble on top; check = (15 - sum mod 15) mod 15.
    function automatic logic [W+3:0] model_frame(input logic [W-1:0] w);
        int sum;
        int chk;
        sum = 0;
        for (int i = 0; i < N; i++) sum += int'((w >> (4 * i)) & 32'hF);
        chk = (15 - (sum % 15)) % 15;
        return {chk[3:0], w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a word and returns in the cycle after it is accepted.
    task automatic drive_word(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 0; c < 100 && !in_ready; c++) tick();
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    // Collects beats from start_beat until the out_last handshake (bounded).
    task automatic capture_frame(input int start_beat, input int ready_mode);
        int beat;
        beat        = start_beat;
        got_val     = '0;
        got_last_ok = 1'b1;
        got_timeout = 1'b1;
        for (int c = 0; c < 400; c++) begin
            out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (beat <= N) got_val[4*beat +: 4] = out_nibble;
                if (out_last != (beat == N)) got_last_ok = 1'b0;
                beat++;
                if (out_last) begin
                    got_timeout = 1'b0;
                    tick();
                    break;
                end
            end
            tick();
        end
        out_ready = 1'b1;
        got_beats = beat - start_beat;
    endtask

    task automatic check_frame(input string name, input int start_beat);
        logic [W+3:0] mask;
        exp_val = exp_q.pop_front();
        mask    = {(W+4){1'b1}} << (4 * start_beat);
        n_vec++;
        if (got_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL %s timeout: no out_last handshake within budget", name);
        end
        n_vec++;
        if ((got_val & mask) !== (exp_val & mask)) begin
            n_err++;
            $display("FAIL %s frame: got %h expected %h", name, got_val & mask, exp_val & mask);
        end
        n_vec++;
        if (got_beats !== N + 1 - start_beat || got_last_ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s beats: got %0d last_ok=%0b expected %0d last_ok=1",
                     name, got_beats, got_last_ok, N + 1 - start_beat);
        end
        n_vec++;
        if ((got_val % 5) !== 0 && start_beat == 0) begin
            n_err++;
            $display("FAIL %s div5: frame %h mod 5 = %0d expected 0", name, got_val, got_val % 5);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, out_last, out_nibble} !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_last=%b nibble=%h expected 1 0 0 0",
                     in_ready, out_valid, out_last, out_nibble);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] vecs[5];
        vecs = '{32'h0000_0005, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_000A};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(model_frame(vecs[i]));
            drive_word(vecs[i]);
            n_vec++;
            if (out_valid !== 1'b1 || out_nibble !== vecs[i][3:0] || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL latency[%0d]: valid=%b nibble=%h ready=%b expected 1 %h 0",
                         i, out_valid, out_nibble, in_ready, vecs[i][3:0]);
            end
            capture_frame(0, 0);
            check_frame("directed", 0);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w;
        w = 32'h1234_5678;
        exp_q.push_back(model_frame(w));
        drive_word(w);
        tick();
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            n_vec++;
            if (out_valid !== 1'b1 || out_nibble !== 4'h6 || in_ready !== 1'b0 || out_last !== 1'b0) begin
                n_err++;
                $display("FAIL stall[%0d]: valid=%b nibble=%h ready=%b last=%b expected 1 6 0 0",
                         c, out_valid, out_nibble, in_ready, out_last);
            end
            tick();
        end
        in_valid = 1'b0;
        capture_frame(2, 0);
        check_frame("backpressure", 2);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'($urandom);
        b = W'($urandom);
        exp_q.push_back(model_frame(a));
        exp_q.push_back(model_frame(b));
        in_valid = 1'b1;
        in_data  = a;
        tick();
        in_data = b;
        capture_frame(0, 0);
        check_frame("b2b_first", 0);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_nibble !== b[3:0] || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: valid=%b nibble=%h ready=%b expected 1 %h 0",
                     out_valid, out_nibble, in_ready, b[3:0]);
        end
        capture_frame(0, 0);
        check_frame("b2b_second", 0);
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] w;
        logic         saw_last;
        w = W'($urandom);
        saw_last = 1'b0;
        drive_word(w);
        for (int c = 0; c < 4; c++) begin
            saw_last |= out_last;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            saw_last |= out_last;
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_nibble !== 4'h0) begin
                n_err++;
                $display("FAIL abort[%0d]: valid=%b ready=%b nibble=%h expected 0 1 0",
                         c, out_valid, in_ready, out_nibble);
            end
            tick();
        end
        n_vec++;
        if (saw_last !== 1'b0) begin
            n_err++;
            $display("FAIL abort_last: out_last seen=%b expected 0", saw_last);
        end
        // Reset wins over a simultaneous input handshake.
        in_valid = 1'b1;
        in_data  = W'($urandom);
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_vs_hs: valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        w = 32'h0000_000A;
        exp_q.push_back(model_frame(w));
        drive_word(w);
        capture_frame(0, 0);
        check_frame("after_abort", 0);
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        for (int i = 0; i < 25; i++) begin
            w = W'($urandom);
            if (i % 5 == 0) w = {W{1'b1}} ^ (W'(1) << $urandom_range(0, W - 1));
            exp_q.push_back(model_frame(w));
            drive_word(w);
            capture_frame(0, 1);
            check_frame("random", 0);
            for (int c = 0; c < $urandom_range(0, 2); c++) tick();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
